// File: rtl/riscv_defs.sv
// Shared core definitions: memory-port arbiter state encoding
// and default data-streak limit.
package riscv_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } arb_state_e;

  localparam int MAX_DM_STREAK_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; fetch is forced in after MAX_DM_STREAK data grants.
module mem_port_arbiter
  import riscv_defs::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int SW = $clog2(MAX_DM_STREAK + 2);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  arb_state_e        r_state;
  logic [SW-1:0]     r_streak;
  logic              r_drop;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;

  logic w_if_done;
  logic w_dm_done;
  logic w_if_ok;
  logic w_if_yield;

  assign w_if_done  = (r_state == GNT_IF) && mem_ready;
  assign w_dm_done  = (r_state == GNT_DM) && mem_ready;
  // A redirect in the completion cycle kills the stale fetch too
  assign w_if_ok    = w_if_done && !r_drop && !if_flush;
  assign w_if_yield = if_req && (r_streak == STREAK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_drop   <= 1'b0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (dm_req && !w_if_yield) begin
            r_state <= GNT_DM;
            r_addr  <= dm_addr;
            r_we    <= dm_we;
            r_wdata <= dm_wdata;
          end else if (if_req) begin
            r_state <= GNT_IF;
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_wdata <= '0;
          end
        end
        GNT_IF: begin
          if (mem_ready) begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_drop   <= 1'b0;
          end else if (if_flush) begin
            r_drop <= 1'b1;
          end
        end
        GNT_DM: begin
          if (mem_ready) begin
            r_state <= IDLE;
            if (!if_req) begin
              r_streak <= '0;
            end else if (r_streak != STREAK_MAX) begin
              r_streak <= r_streak + SW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_valid = (r_state != IDLE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_ready  = w_if_ok;
  assign dm_ready  = w_dm_done;
  assign if_rdata  = w_if_ok ? mem_rdata : '0;
  assign dm_rdata  = w_dm_done ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level
// model predicts grants and responses, a monitor checks them.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_ready;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_valid, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic          is_if;
    logic [DW-1:0] data;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_valid = 1'b0;
  bit mon_en = 1'b0;

  // transaction-level model: who owns the port, data-win streak, kill flag
  int owner = 0;
  int streak = 0;
  bit drop = 1'b0;
  bit if_act = 1'b0;
  bit dm_act = 1'b0;

  function automatic void chk(bit ok, string name,
                              logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cycle(input int p_if, input int p_dm, input int p_rdy,
                       input int p_fl, input int p_rst_pm);
    @(negedge clk);
    exp_valid = (owner != 0);
    if (!if_act && $urandom_range(99) < p_if) begin
      if_act  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dm_act && $urandom_range(99) < p_dm) begin
      dm_act   = 1'b1;
      dm_we    = $urandom_range(1);
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    if_req    = if_act;
    dm_req    = dm_act;
    if_flush  = ($urandom_range(99) < p_fl);
    rst       = ($urandom_range(999) < p_rst_pm);
    mem_ready = rst ? 1'b0 : ($urandom_range(99) < p_rdy);
    mem_rdata = $urandom;
    if (rst) begin
      owner  = 0;
      streak = 0;
      drop   = 1'b0;
      if_act = 1'b0;
      dm_act = 1'b0;
    end else if (owner != 0 && mem_ready) begin
      if (owner == 1) begin
        if (!drop && !if_flush) rq.push_back('{1'b1, mem_rdata});
        if_act = 1'b0;
        streak = 0;
        drop   = 1'b0;
      end else begin
        rq.push_back('{1'b0, mem_rdata});
        dm_act = 1'b0;
        if (!if_req) streak = 0;
        else if (streak < MAXS) streak++;
      end
      owner = 0;
    end else if (owner == 1 && if_flush) begin
      drop = 1'b1;
    end else if (owner == 0) begin
      if (dm_req && !(if_req && streak == MAXS)) begin
        owner = 2;
        gq.push_back('{dm_addr, dm_we, dm_wdata});
      end else if (if_req) begin
        owner = 1;
        gq.push_back('{if_addr, 1'b0, '0});
      end
    end
  endtask

  initial begin : monitor
    gnt_t cur;
    gnt_t exp_g;
    rsp_t exp_r;
    bit   prev_v;
    prev_v = 1'b0;
    cur    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) continue;
      chk(mem_valid === exp_valid, "mem_valid", 64'(mem_valid), 64'(exp_valid));
      if (mem_valid && !prev_v) begin
        cur = '{mem_addr, mem_we, mem_wdata};
        if (gq.size() == 0) begin
          chk(1'b0, "unexpected_grant", 64'(cur.addr), 64'd0);
        end else begin
          exp_g = gq.pop_front();
          chk(cur == exp_g, "grant_addr", 64'(cur.addr), 64'(exp_g.addr));
          chk(cur.we == exp_g.we && cur.wdata == exp_g.wdata, "grant_we_wdata",
              {31'd0, cur.we, cur.wdata}, {31'd0, exp_g.we, exp_g.wdata});
        end
      end else if (mem_valid) begin
        chk(cur == gnt_t'{mem_addr, mem_we, mem_wdata}, "grant_stable",
            64'(mem_addr), 64'(cur.addr));
      end
      prev_v = mem_valid;
      chk(!(if_ready && dm_ready), "both_ready",
          64'({if_ready, dm_ready}), 64'd0);
      if (if_ready || dm_ready) begin
        if (rq.size() == 0) begin
          chk(1'b0, "unexpected_ready", 64'({if_ready, dm_ready}), 64'd0);
        end else begin
          exp_r = rq.pop_front();
          chk(if_ready == exp_r.is_if, "ready_port",
              64'(if_ready), 64'(exp_r.is_if));
          chk((if_ready ? if_rdata : dm_rdata) == exp_r.data, "rdata",
              64'(if_ready ? if_rdata : dm_rdata), 64'(exp_r.data));
        end
      end
      if (!if_ready && if_rdata != '0)
        chk(1'b0, "if_rdata_idle", 64'(if_rdata), 64'd0);
      if (!dm_ready && dm_rdata != '0)
        chk(1'b0, "dm_rdata_idle", 64'(dm_rdata), 64'd0);
    end
  end

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    cycle(0, 0, 0, 0, 1000);
    cycle(0, 0, 0, 0, 1000);
    mon_en = 1'b1;
    for (int i = 0; i < 400; i++) cycle(40, 40, 50, 10, 5);
    for (int i = 0; i < 120; i++) cycle(100, 100, 100, 0, 0);
    for (int i = 0; i < 400; i++) cycle(60, 60, 25, 20, 10);
    for (int i = 0; i < 100; i++) cycle(100, 100, 70, 5, 0);
    for (int i = 0; i < 30; i++) cycle(0, 0, 100, 0, 0);
    @(negedge clk);
    #2;
    chk(gq.size() == 0, "grants_left", 64'(gq.size()), 64'd0);
    chk(rq.size() == 0, "responses_left", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; MAX_DM_STREAK, default 2, consecutive data grants allowed while fetch waits.
REQ-002 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  fetch redirect (branch/jump taken).
- if_rdata  out  DATA_W  fetch read data.
- if_ready  out  1  fetch completion pulse.
- dm_req  in  1  data request.
- dm_we  in  1  data write.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  data write data.
- dm_rdata  out  DATA_W  data read data.
- dm_ready  out  1  data completion pulse.
- mem_valid  out  1  memory request valid.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion.

Function
REQ-003 FSM states SHALL be IDLE, GNT_IF and GNT_DM.
REQ-004 In IDLE with dm_req=1, the FSM SHALL go to GNT_DM, unless if_req=1 and streak==MAX_DM_STREAK, in which case it SHALL go to GNT_IF.
REQ-005 In IDLE with only if_req=1, the FSM SHALL go to GNT_IF; with no request it SHALL stay in IDLE.
REQ-006 mem_valid SHALL be 1 exactly when the state is GNT_IF or GNT_DM.
REQ-007 The mem_addr, mem_we and mem_wdata values SHALL be captured into registers on the grant edge and held stable until completion; mem_we and mem_wdata SHALL be 0 for fetch.
REQ-008 Completion SHALL occur in the cycle where mem_valid=1 and mem_ready=1, after which the FSM SHALL return to IDLE.
REQ-009 Minimum latency SHALL be: request in IDLE at cycle N, mem_valid at N+1, ready earliest at N+1.
REQ-010 On completion, if_ready or dm_ready SHALL pulse for exactly one cycle, combinationally with mem_ready; the matching rdata SHALL equal mem_rdata in that cycle and be 0 otherwise.
REQ-011 Requesters SHALL hold req and operands until ready; the arbiter SHALL NOT sample operands after the grant edge.
REQ-012 streak SHALL increment, saturating at MAX_DM_STREAK, on each data completion while if_req=1.
REQ-013 streak SHALL clear on any fetch completion, and on a data completion with if_req=0.
REQ-014 If if_flush=1 in any cycle of GNT_IF, a drop flag SHALL set; the memory transaction SHALL still complete.
REQ-015 While the drop flag is set, if_ready SHALL be suppressed at completion; the flag SHALL clear on completion.
REQ-016 if_flush in IDLE or GNT_DM SHALL have no effect.
REQ-017 if_flush coinciding with the completion cycle SHALL suppress if_ready.
REQ-018 When dm_req and if_req are simultaneous with streak below the limit, data SHALL win.

Reset
REQ-019 On rst=1, the state SHALL become IDLE; streak, drop flag and the captured registers SHALL become 0.
REQ-020 mem_valid, if_ready and dm_ready SHALL be 0 in the cycle after rst and thereafter until a new grant.
REQ-021 Reset mid-transaction SHALL abandon the transaction without a ready pulse; the memory SHALL tolerate a dropped valid.

Structure
REQ-022 The state encoding and the MAX_DM_STREAK default SHALL reside in the shared riscv_defs package/header.
REQ-023 The design SHALL be a single module with no sub-modules.

Verification
REQ-024 Single fetch: if_req, if_addr=0x100, mem_ready at 2nd mem_valid cycle, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_ready pulses once with if_rdata=0x00500093.
REQ-025 Contention: if_req and dm_req from the same cycle, MAX_DM_STREAK=2, zero-wait memory -> grant order DM, DM, IF, DM; streak returns to 0 after the IF grant.
REQ-026 Store: dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF, mem_ready after 3 cycles -> mem fields stable all 3 cycles; dm_ready pulses once; if_ready stays 0.
REQ-027 Flush: if_flush pulsed during GNT_IF, with 2-cycle memory -> transaction completes, if_ready stays 0, FSM in IDLE; a new if_addr=0x200 is then served normally.
REQ-028 Reset: rst asserted during GNT_DM before mem_ready -> next cycle mem_valid=0, dm_ready=0, state IDLE, streak 0.
